match_pe_arbiter: RTL and testbench

//   Shares one match_pe between NUM_REQ job PEs. Round-robin arbitration picks the next match request.
//   The requester index is prepended to the request tag, so responses route back by tag.
//   A per-requester credit limits how many matches each requester can have in flight.

---
 rtl/match_pe_arbiter_if.sv | 54 +++++
 rtl/match_pe_arbiter.sv | 172 +++++++++++++++++
 tb/tb_match_pe_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_pe_arbiter_if.sv
// Request/response bundle between the job PE array, the arbiter and the shared match_pe.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif

interface match_pe_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_TAG_BITS = 6
);
  localparam int IDX_BITS    = $clog2(NUM_REQ);
  localparam int PE_TAG_BITS = IDX_BITS + REQ_TAG_BITS;
  localparam int AW          = `ADDR_WIDTH;
  localparam int LW          = `MAX_MATCH_LEN_LOG2 + 1;

  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ-1:0]              o_req_ready;
  logic [NUM_REQ*REQ_TAG_BITS-1:0] i_req_tag;
  logic [NUM_REQ*AW-1:0]           i_req_head_addr;
  logic [NUM_REQ*AW-1:0]           i_req_history_addr;
  logic [NUM_REQ-1:0]              o_resp_valid;
  logic [NUM_REQ-1:0]              i_resp_ready;
  logic [REQ_TAG_BITS-1:0]         o_resp_tag;
  logic [LW-1:0]                   o_resp_match_len;
  logic                            o_pe_req_valid;
  logic                            i_pe_req_ready;
  logic [PE_TAG_BITS-1:0]          o_pe_req_tag;
  logic [AW-1:0]                   o_pe_req_head_addr;
  logic [AW-1:0]                   o_pe_req_history_addr;
  logic                            i_pe_resp_valid;
  logic                            o_pe_resp_ready;
  logic [PE_TAG_BITS-1:0]          i_pe_resp_tag;
  logic [LW-1:0]                   i_pe_resp_match_len;
  logic                            o_busy;
  logic                            o_err;

  modport slave (
    input  i_req_valid, i_req_tag, i_req_head_addr, i_req_history_addr, i_resp_ready,
    input  i_pe_req_ready, i_pe_resp_valid, i_pe_resp_tag, i_pe_resp_match_len,
    output o_req_ready, o_resp_valid, o_resp_tag, o_resp_match_len,
    output o_pe_req_valid, o_pe_req_tag, o_pe_req_head_addr, o_pe_req_history_addr,
    output o_pe_resp_ready, o_busy, o_err
  );

  modport master (
    output i_req_valid, i_req_tag, i_req_head_addr, i_req_history_addr, i_resp_ready,
    output i_pe_req_ready, i_pe_resp_valid, i_pe_resp_tag, i_pe_resp_match_len,
    input  o_req_ready, o_resp_valid, o_resp_tag, o_resp_match_len,
    input  o_pe_req_valid, o_pe_req_tag, o_pe_req_head_addr, o_pe_req_history_addr,
    input  o_pe_resp_ready, o_busy, o_err
  );
endinterface

// File: rtl/match_pe_arbiter.sv
// Round-robin share of one match_pe among NUM_REQ job PEs with per-requester credits.
// One registered stage per direction (latency 1); a stalled requester blocks all responses.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif

module match_pe_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_TAG_BITS    = 6,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  match_pe_arbiter_if.slave bus
);
  localparam int IDX_BITS    = $clog2(NUM_REQ);
  localparam int PE_TAG_BITS = IDX_BITS + REQ_TAG_BITS;
  localparam int CNT_BITS    = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW          = `ADDR_WIDTH;
  localparam int LW          = `MAX_MATCH_LEN_LOG2 + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [IDX_BITS:0]   NUM_REQ_W = (IDX_BITS+1)'(NUM_REQ);

  logic [IDX_BITS-1:0]     rr_ptr;
  logic [CNT_BITS-1:0]     cnt [NUM_REQ];
  logic                    req_vld;
  logic [PE_TAG_BITS-1:0]  req_tag;
  logic [AW-1:0]           req_head;
  logic [AW-1:0]           req_hist;
  logic                    resp_vld;
  logic [IDX_BITS-1:0]     resp_idx;
  logic [REQ_TAG_BITS-1:0] resp_tag;
  logic [LW-1:0]           resp_len;
  logic                    err;

  logic [NUM_REQ-1:0]      eligible;
  logic                    found;
  logic [IDX_BITS-1:0]     winner;
  logic                    grant;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [REQ_TAG_BITS-1:0] sel_tag;
  logic [AW-1:0]           sel_head;
  logic [AW-1:0]           sel_hist;
  logic [NUM_REQ-1:0]      resp_oh;
  logic [NUM_REQ-1:0]      resp_hs_oh;
  logic                    resp_hs;
  logic                    pe_resp_rdy;
  logic                    pe_resp_fire;
  logic [IDX_BITS-1:0]     in_idx;
  logic                    in_idx_ok;
  logic                    underflow;
  logic                    cnt_any;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = bus.i_req_valid[k] && (cnt[k] < CNT_MAX);
    end
  end

  // Scan from rr_ptr upward, wrapping at NUM_REQ; first eligible index wins.
  always_comb begin
    logic [IDX_BITS:0] cand;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_BITS+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && eligible[cand[IDX_BITS-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_BITS-1:0];
      end
    end
  end

  assign grant = ~rst & found & (~req_vld | bus.i_pe_req_ready);

  always_comb begin
    grant_oh = '0;
    sel_tag  = '0;
    sel_head = '0;
    sel_hist = '0;
    resp_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IDX_BITS'(k)) begin
        sel_tag  = bus.i_req_tag[k*REQ_TAG_BITS +: REQ_TAG_BITS];
        sel_head = bus.i_req_head_addr[k*AW +: AW];
        sel_hist = bus.i_req_history_addr[k*AW +: AW];
      end
    end
    if (grant)    grant_oh[winner] = 1'b1;
    if (resp_vld) resp_oh[resp_idx] = 1'b1;
  end

  assign resp_hs_oh   = resp_oh & bus.i_resp_ready;
  assign resp_hs      = |resp_hs_oh;
  assign pe_resp_rdy  = ~rst & (~resp_vld | resp_hs);
  assign pe_resp_fire = bus.i_pe_resp_valid & pe_resp_rdy;
  assign in_idx       = bus.i_pe_resp_tag[PE_TAG_BITS-1 -: IDX_BITS];
  assign in_idx_ok    = {1'b0, in_idx} < NUM_REQ_W;

  always_comb begin
    underflow = 1'b0;
    cnt_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      underflow = underflow | (resp_hs_oh[k] & (cnt[k] == '0));
      cnt_any   = cnt_any | (cnt[k] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      req_vld  <= 1'b0;
      req_tag  <= '0;
      req_head <= '0;
      req_hist <= '0;
      resp_vld <= 1'b0;
      resp_idx <= '0;
      resp_tag <= '0;
      resp_len <= '0;
      err      <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    end else begin
      if (grant) begin
        rr_ptr   <= (winner == IDX_BITS'(NUM_REQ - 1)) ? '0 : winner + IDX_BITS'(1);
        req_vld  <= 1'b1;
        req_tag  <= {winner, sel_tag};
        req_head <= sel_head;
        req_hist <= sel_hist;
      end else if (bus.i_pe_req_ready) begin
        req_vld  <= 1'b0;
      end

      // Responses carrying an out-of-range index are swallowed here and flagged.
      if (pe_resp_fire && in_idx_ok) begin
        resp_vld <= 1'b1;
        resp_idx <= in_idx;
        resp_tag <= bus.i_pe_resp_tag[REQ_TAG_BITS-1:0];
        resp_len <= bus.i_pe_resp_match_len;
      end else if (resp_hs) begin
        resp_vld <= 1'b0;
      end

      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_oh[k] && !resp_hs_oh[k]) begin
          cnt[k] <= cnt[k] + CNT_ONE;
        end else if (resp_hs_oh[k] && !grant_oh[k] && cnt[k] != '0) begin
          cnt[k] <= cnt[k] - CNT_ONE;
        end
      end

      if ((pe_resp_fire && !in_idx_ok) || underflow) err <= 1'b1;
    end
  end

  assign bus.o_req_ready           = grant_oh;
  assign bus.o_resp_valid          = resp_oh;
  assign bus.o_resp_tag            = resp_tag;
  assign bus.o_resp_match_len      = resp_len;
  assign bus.o_pe_req_valid        = req_vld;
  assign bus.o_pe_req_tag          = req_tag;
  assign bus.o_pe_req_head_addr    = req_head;
  assign bus.o_pe_req_history_addr = req_hist;
  assign bus.o_pe_resp_ready       = pe_resp_rdy;
  assign bus.o_busy                = cnt_any | req_vld | resp_vld;
  assign bus.o_err                 = err;
endmodule

// File: tb/tb_match_pe_arbiter.sv
// Bench for match_pe_arbiter: grant table with request scoreboard, plus hand-written response/credit/reset sequences.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif

module tb_match_pe_arbiter;
  localparam int NR = 4;
  localparam int TB = 6;
  localparam int AW = `ADDR_WIDTH;
  localparam int LW = `MAX_MATCH_LEN_LOG2 + 1;

  typedef struct {
    bit         rst_before;
    logic [3:0] req_valid;
    bit         pe_ready;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [7:0]    tag;
    logic [AW-1:0] head;
    logic [AW-1:0] hist;
  } req_exp_t;

  typedef struct {
    logic [3:0]    vld;
    logic [TB-1:0] tag;
    logic [LW-1:0] len;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_t      vecs[$];
  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];

  match_pe_arbiter_if #(.NUM_REQ(NR), .REQ_TAG_BITS(TB)) bus ();

  match_pe_arbiter #(.NUM_REQ(NR), .REQ_TAG_BITS(TB), .MAX_OUTSTANDING(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    bus.i_req_valid         = '0;
    bus.i_req_tag           = '0;
    bus.i_req_head_addr     = '0;
    bus.i_req_history_addr  = '0;
    bus.i_resp_ready        = '0;
    bus.i_pe_req_ready      = 1'b0;
    bus.i_pe_resp_valid     = 1'b0;
    bus.i_pe_resp_tag       = '0;
    bus.i_pe_resp_match_len = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_q.delete();
    resp_q.delete();
  endtask

  task automatic pe_send(input logic [1:0] idx, input logic [TB-1:0] tag, input logic [LW-1:0] len);
    resp_exp_t e;
    bus.i_pe_resp_valid     = 1'b1;
    bus.i_pe_resp_tag       = {idx, tag};
    bus.i_pe_resp_match_len = len;
    e.vld = 4'b0001 << idx;
    e.tag = tag;
    e.len = len;
    resp_q.push_back(e);
  endtask

  task automatic check_resp(input string name);
    resp_exp_t e;
    if (resp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expected response queued", name);
    end else begin
      e = resp_q.pop_front();
      check({name, "_vld"}, bus.o_resp_valid, e.vld);
      check({name, "_tag"}, bus.o_resp_tag, e.tag);
      check({name, "_len"}, bus.o_resp_match_len, e.len);
    end
  endtask

  function automatic void add(bit r, logic [3:0] v, bit p, logic [3:0] e);
    vec_t x;
    x.rst_before = r;
    x.req_valid  = v;
    x.pe_ready   = p;
    x.exp_ready  = e;
    vecs.push_back(x);
  endfunction

  function automatic logic [TB-1:0] tag_of(int i, int k);
    return TB'((i * 4 + k) & 63);
  endfunction

  function automatic logic [AW-1:0] head_of(int i, int k);
    return AW'(16'h1000 + i * 16 + k);
  endfunction

  function automatic logic [AW-1:0] hist_of(int i, int k);
    return AW'(16'h8000 + i * 16 + k);
  endfunction

  initial begin
    req_exp_t held;
    req_exp_t e;
    bit       exp_vld;
    bit       pend;
    int       w;

    // Fair rotation with all requesters valid; credits run out after two each.
    for (int k = 0; k < 8; k++) add(k == 0, 4'hF, 1'b1, 4'b0001 << (k % 4));
    add(0, 4'hF, 1'b1, 4'b0000);
    // match_pe stalled: register holds, no grants until ready rises.
    add(1, 4'hF, 1'b0, 4'b0001);
    for (int k = 0; k < 5; k++) add(0, 4'hF, 1'b0, 4'b0000);
    add(0, 4'hF, 1'b1, 4'b0010);
    add(0, 4'hF, 1'b0, 4'b0000);
    // Sparse patterns exercising pointer skip and credit exhaustion.
    add(1, 4'b1010, 1'b1, 4'b0010);
    add(0, 4'b1010, 1'b1, 4'b1000);
    add(0, 4'b0101, 1'b1, 4'b0001);
    add(0, 4'b0101, 1'b1, 4'b0100);
    add(0, 4'b0001, 1'b1, 4'b0001);
    add(0, 4'b0001, 1'b1, 4'b0000);
    add(0, 4'b1011, 1'b1, 4'b0010);
    add(0, 4'b1011, 1'b1, 4'b1000);
    add(0, 4'b1011, 1'b1, 4'b0000);
    add(0, 4'b1111, 1'b1, 4'b0100);
    add(0, 4'b1111, 1'b1, 4'b0000);

    zero_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_pe_req_vld", bus.o_pe_req_valid, 0);
    check("rst_pe_resp_rdy", bus.o_pe_resp_ready, 0);
    check("rst_err", bus.o_err, 0);
    rst = 1'b0;

    exp_vld = 1'b0;
    pend    = 1'b0;
    held    = '{default: '0};
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        do_reset();
        exp_vld = 1'b0;
        pend    = 1'b0;
      end
      @(negedge clk);
      check($sformatf("tbl%0d_pe_vld", i), bus.o_pe_req_valid, exp_vld);
      if (pend) begin
        e = req_q.pop_front();
        check($sformatf("tbl%0d_pe_tag", i), bus.o_pe_req_tag, e.tag);
        check($sformatf("tbl%0d_pe_head", i), bus.o_pe_req_head_addr, e.head);
        check($sformatf("tbl%0d_pe_hist", i), bus.o_pe_req_history_addr, e.hist);
        held = e;
      end else if (exp_vld) begin
        check($sformatf("tbl%0d_hold_tag", i), bus.o_pe_req_tag, held.tag);
        check($sformatf("tbl%0d_hold_head", i), bus.o_pe_req_head_addr, held.head);
      end
      bus.i_req_valid    = vecs[i].req_valid;
      bus.i_pe_req_ready = vecs[i].pe_ready;
      for (int k = 0; k < NR; k++) begin
        bus.i_req_tag[k*TB +: TB]          = tag_of(i, k);
        bus.i_req_head_addr[k*AW +: AW]    = head_of(i, k);
        bus.i_req_history_addr[k*AW +: AW] = hist_of(i, k);
      end
      #1;
      check($sformatf("tbl%0d_grant", i), bus.o_req_ready, vecs[i].exp_ready);
      pend = (vecs[i].exp_ready != 4'b0000);
      if (pend) begin
        w = 0;
        for (int k = 0; k < NR; k++) if (vecs[i].exp_ready[k]) w = k;
        e.tag  = {2'(w), tag_of(i, w)};
        e.head = head_of(i, w);
        e.hist = hist_of(i, w);
        req_q.push_back(e);
        exp_vld = 1'b1;
      end else if (vecs[i].pe_ready) begin
        exp_vld = 1'b0;
      end
    end

    // Credit limit on a lone requester, then one response frees a slot.
    do_reset();
    bus.i_req_valid        = 4'b0100;
    bus.i_req_tag[17:12]   = 6'h2A;
    bus.i_pe_req_ready     = 1'b1;
    #1 check("t2_acc1", bus.o_req_ready, 4'b0100);
    tick();
    check("t2_pe_tag", bus.o_pe_req_tag, 8'hAA);
    #1 check("t2_acc2", bus.o_req_ready, 4'b0100);
    tick();
    #1 check("t2_credit_block", bus.o_req_ready, 4'b0000);
    check("t2_busy", bus.o_busy, 1);
    pe_send(2'd2, 6'h15, LW'(17));
    #1 check("t2_pe_resp_rdy", bus.o_pe_resp_ready, 1);
    tick();
    bus.i_pe_resp_valid = 1'b0;
    #1 check_resp("t2_resp");
    check("t2_still_blocked", bus.o_req_ready, 4'b0000);
    bus.i_resp_ready = 4'b0100;
    tick();
    bus.i_resp_ready = 4'b0000;
    #1 check("t2_resp_cleared", bus.o_resp_valid, 4'b0000);
    check("t2_reaccept", bus.o_req_ready, 4'b0100);
    tick();
    bus.i_req_valid = 4'b0000;

    // Stalled requester 1 blocks a queued response for requester 3.
    do_reset();
    bus.i_req_valid    = 4'b1010;
    bus.i_pe_req_ready = 1'b1;
    tick();
    tick();
    bus.i_req_valid = 4'b0000;
    #1 check("t4_busy", bus.o_busy, 1);
    pe_send(2'd1, 6'h05, LW'(3));
    tick();
    pe_send(2'd3, 6'h07, LW'(9));
    #1 check_resp("t4_first");
    check("t4_pe_resp_blocked", bus.o_pe_resp_ready, 0);
    tick();
    #1 check("t4_still_first", bus.o_resp_valid, 4'b0010);
    check("t4_still_blocked", bus.o_pe_resp_ready, 0);
    bus.i_resp_ready = 4'b0010;
    #1 check("t4_unblock", bus.o_pe_resp_ready, 1);
    tick();
    bus.i_pe_resp_valid = 1'b0;
    bus.i_resp_ready    = 4'b1000;
    #1 check_resp("t4_second");
    tick();
    bus.i_resp_ready = 4'b0000;
    #1 check("t4_drained", bus.o_resp_valid, 4'b0000);
    check("t4_idle", bus.o_busy, 0);
    check("t4_no_err", bus.o_err, 0);

    // Same-cycle accept and response keep the count; response to idle requester raises sticky error.
    do_reset();
    bus.i_req_valid    = 4'b0001;
    bus.i_pe_req_ready = 1'b1;
    tick();
    bus.i_req_valid = 4'b0000;
    pe_send(2'd0, 6'h11, LW'(5));
    tick();
    bus.i_pe_resp_valid = 1'b0;
    #1 check_resp("t5_resp0");
    bus.i_req_valid  = 4'b0001;
    bus.i_resp_ready = 4'b0001;
    #1 check("t5_same_acc", bus.o_req_ready, 4'b0001);
    tick();
    bus.i_resp_ready = 4'b0000;
    #1 check("t5_cnt_kept", bus.o_req_ready, 4'b0001);
    tick();
    #1 check("t5_cnt_full", bus.o_req_ready, 4'b0000);
    bus.i_req_valid = 4'b0000;
    check("t5_err_clean", bus.o_err, 0);
    pe_send(2'd2, 6'h3F, LW'(1));
    tick();
    bus.i_pe_resp_valid = 1'b0;
    #1 check_resp("t5_idle_resp");
    bus.i_resp_ready = 4'b0100;
    tick();
    bus.i_resp_ready = 4'b0000;
    #1 check("t5_err_set", bus.o_err, 1);
    bus.i_req_valid = 4'b0100;
    #1 check("t5_cnt_sat", bus.o_req_ready, 4'b0100);
    bus.i_req_valid = 4'b0000;
    repeat (3) tick();
    check("t5_err_sticky", bus.o_err, 1);

    // Asynchronous reset with both registers loaded.
    do_reset();
    bus.i_req_valid    = 4'hF;
    bus.i_pe_req_ready = 1'b0;
    tick();
    pe_send(2'd0, 6'h2B, LW'(7));
    tick();
    bus.i_pe_resp_valid = 1'b0;
    #1 check("t6_pe_req_vld", bus.o_pe_req_valid, 1);
    check_resp("t6_resp");
    rst = 1'b1;
    #1 check("t6_rst_ready", bus.o_req_ready, 4'b0000);
    check("t6_rst_pe_vld", bus.o_pe_req_valid, 0);
    check("t6_rst_pe_tag", bus.o_pe_req_tag, 0);
    check("t6_rst_resp_vld", bus.o_resp_valid, 4'b0000);
    check("t6_rst_pe_resp_rdy", bus.o_pe_resp_ready, 0);
    check("t6_rst_busy", bus.o_busy, 0);
    check("t6_rst_err", bus.o_err, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_pe_req_ready = 1'b1;
    #1 check("t6_grant0", bus.o_req_ready, 4'b0001);
    tick();
    bus.i_req_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
